// File: rtl/mic_frame_buffer.sv
// Ping-pong frame buffer between the decimated microphone stream and the FFT.
// One bank fills while the other is presented; samples arriving with both banks busy are dropped and counted.
module mic_frame_buffer #(
    parameter int WIDTH   = 32,
    parameter int SAMPLES = 16,
    parameter int DECIM   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_sample,
    input  logic                       flush,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic [SAMPLES*WIDTH-1:0]   frame_data,
    output logic [15:0]                frame_seq,
    output logic                       overrun,
    output logic [15:0]                drop_count,
    input  logic                       clr_overrun
);

    localparam int IW = $clog2(SAMPLES);
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES - 1);
    localparam logic [DW-1:0] LAST_DEC = DW'(DECIM - 1);

    typedef enum logic {FILL, FULL_WAIT} state_t;

    state_t                             state_q, state_d;
    logic [IW-1:0]                      widx_q, widx_d;
    logic [DW-1:0]                      dcnt_q, dcnt_d;
    logic [SAMPLES-1:0][WIDTH-1:0]      wbuf_q, wbuf_d;
    logic [SAMPLES-1:0][WIDTH-1:0]      frame_q, frame_d;
    logic                               frame_valid_q, frame_valid_d;
    logic [15:0]                        frame_seq_q, frame_seq_d;
    logic                               overrun_q, overrun_d;
    logic [15:0]                        drop_count_q, drop_count_d;

    logic keep, release_rd, drop;

    always_comb begin
        state_d       = state_q;
        widx_d        = widx_q;
        dcnt_d        = dcnt_q;
        wbuf_d        = wbuf_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
        frame_seq_d   = frame_seq_q;
        overrun_d     = overrun_q;
        drop_count_d  = drop_count_q;
        drop          = 1'b0;

        keep       = in_valid & (dcnt_q == '0);
        release_rd = frame_valid_q & frame_ready;

        if (flush) begin
            dcnt_d = '0;
        end else if (in_valid) begin
            dcnt_d = (dcnt_q == LAST_DEC) ? '0 : dcnt_q + 1'b1;
        end

        // A swap below overrides this when the read bank is refilled on the same edge.
        if (release_rd) begin
            frame_valid_d = 1'b0;
        end

        if (flush) begin
            widx_d  = '0;
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (keep) begin
                        wbuf_d[widx_q] = in_sample;
                        if (widx_q == LAST_IDX) begin
                            widx_d = '0;
                            if (!frame_valid_q || release_rd) begin
                                frame_d       = wbuf_d;
                                frame_valid_d = 1'b1;
                                frame_seq_d   = frame_seq_q + 16'd1;
                            end else begin
                                state_d = FULL_WAIT;
                            end
                        end else begin
                            widx_d = widx_q + 1'b1;
                        end
                    end
                end
                FULL_WAIT: begin
                    // The new write bank only opens after the swap edge, so a same-cycle sample is lost.
                    drop = keep;
                    if (release_rd) begin
                        frame_d       = wbuf_q;
                        frame_valid_d = 1'b1;
                        frame_seq_d   = frame_seq_q + 16'd1;
                        widx_d        = '0;
                        state_d       = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end

        if (clr_overrun) begin
            overrun_d    = drop;
            drop_count_d = {15'd0, drop};
        end else if (drop) begin
            overrun_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            widx_q        <= '0;
            dcnt_q        <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_seq_q   <= 16'd0;
            overrun_q     <= 1'b0;
            drop_count_q  <= 16'd0;
        end else begin
            state_q       <= state_d;
            widx_q        <= widx_d;
            dcnt_q        <= dcnt_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            frame_seq_q   <= frame_seq_d;
            overrun_q     <= overrun_d;
            drop_count_q  <= drop_count_d;
        end
    end

    // Bank storage is left unreset; it is only exposed after a full frame has been written.
    always_ff @(posedge clk) begin
        wbuf_q <= wbuf_d;
    end

    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_q;
    assign frame_seq   = frame_seq_q;
    assign overrun     = overrun_q;
    assign drop_count  = drop_count_q;

endmodule
